// File: rtl/conv_mem_sequencer.sv
// Sequencer for unsigned linear convolution y[n] = sum x[k]*h[n-k] over X/H RAMs with
// one-cycle registered reads; each finished y[n] goes out through the Y RAM write port.
module conv_mem_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   size_x_i,
  input  logic [ADDR_WIDTH:0]   size_h_i,
  output logic [ADDR_WIDTH-1:0] x_read_addr_o,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  output logic [ADDR_WIDTH-1:0] h_read_addr_o,
  input  logic [DATA_WIDTH-1:0] h_data_i,
  output logic                  y_write_en_o,
  output logic [ADDR_WIDTH:0]   y_write_addr_o,
  output logic [ACC_WIDTH-1:0]  y_write_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned SW = ADDR_WIDTH + 1;
  localparam int unsigned EW = ADDR_WIDTH + 2;
  localparam logic [SW-1:0] MaxSize = SW'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    StIdle, StInit, StRead, StDrain, StWrite, StDone
  } state_e;

  state_e                  r_state, w_state_d;
  logic [SW-1:0]           r_nx, w_nx_d;
  logic [SW-1:0]           r_nh, w_nh_d;
  logic [SW-1:0]           r_n, w_n_d;
  logic [ADDR_WIDTH-1:0]   r_k, w_k_d;
  logic [ADDR_WIDTH-1:0]   r_khi, w_khi_d;
  logic [ACC_WIDTH-1:0]    r_acc, w_acc_d;
  logic                    r_valid, w_valid_d;

  logic [SW-1:0]           w_size_x_clamp, w_size_h_clamp;
  logic [EW-1:0]           w_n_e, w_nx_e, w_nh_e, w_klo_e, w_khi_e;
  logic                    w_last_n;
  logic [ADDR_WIDTH-1:0]   w_h_addr;
  logic [2*DATA_WIDTH-1:0] w_prod;

  assign w_size_x_clamp = (size_x_i > MaxSize) ? MaxSize : size_x_i;
  assign w_size_h_clamp = (size_h_i > MaxSize) ? MaxSize : size_h_i;

  // Bounds are computed one bit wider so n+1 and Nx+Nh never wrap.
  assign w_n_e    = EW'(r_n);
  assign w_nx_e   = EW'(r_nx);
  assign w_nh_e   = EW'(r_nh);
  assign w_klo_e  = (w_n_e + EW'(1) >= w_nh_e) ? (w_n_e + EW'(1) - w_nh_e) : '0;
  assign w_khi_e  = (w_n_e < w_nx_e - EW'(1)) ? w_n_e : (w_nx_e - EW'(1));
  assign w_last_n = (w_n_e + EW'(2) == w_nx_e + w_nh_e);
  assign w_h_addr = ADDR_WIDTH'(w_n_e - EW'(r_k));
  assign w_prod   = x_data_i * h_data_i;

  assign busy_o = (r_state != StIdle);

  always_comb begin
    w_state_d      = r_state;
    w_nx_d         = r_nx;
    w_nh_d         = r_nh;
    w_n_d          = r_n;
    w_k_d          = r_k;
    w_khi_d        = r_khi;
    w_acc_d        = r_acc;
    w_valid_d      = (r_state == StRead);
    x_read_addr_o  = '0;
    h_read_addr_o  = '0;
    y_write_en_o   = 1'b0;
    y_write_addr_o = '0;
    y_write_data_o = '0;
    done_o         = 1'b0;

    // Data returned for last cycle's READ address is accumulated here.
    if (r_valid) begin
      w_acc_d = r_acc + ACC_WIDTH'(w_prod);
    end

    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_nx_d    = w_size_x_clamp;
          w_nh_d    = w_size_h_clamp;
          w_n_d     = '0;
          w_state_d = StInit;
        end
      end
      StInit: begin
        // A zero size leaves no outputs to produce.
        if (r_nx == '0 || r_nh == '0) begin
          w_state_d = StDone;
        end else begin
          w_k_d     = ADDR_WIDTH'(w_klo_e);
          w_khi_d   = ADDR_WIDTH'(w_khi_e);
          w_acc_d   = '0;
          w_state_d = StRead;
        end
      end
      StRead: begin
        x_read_addr_o = r_k;
        h_read_addr_o = w_h_addr;
        if (r_k == r_khi) begin
          w_state_d = StDrain;
        end else begin
          w_k_d = r_k + ADDR_WIDTH'(1);
        end
      end
      StDrain: begin
        w_state_d = StWrite;
      end
      StWrite: begin
        y_write_en_o   = 1'b1;
        y_write_addr_o = r_n;
        y_write_data_o = r_acc;
        if (w_last_n) begin
          w_state_d = StDone;
        end else begin
          w_n_d     = r_n + SW'(1);
          w_state_d = StInit;
        end
      end
      StDone: begin
        done_o    = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_nx    <= '0;
      r_nh    <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_khi   <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_nx    <= w_nx_d;
      r_nh    <= w_nh_d;
      r_n     <= w_n_d;
      r_k     <= w_k_d;
      r_khi   <= w_khi_d;
      r_acc   <= w_acc_d;
      r_valid <= w_valid_d;
    end
  end

endmodule

// File: tb/tb_conv_mem_sequencer.sv
// Scoreboard bench for conv_mem_sequencer: directed runs push expected Y writes and done
// pulses; a monitor pops and compares them whenever the DUT presents a write or done.
module tb_conv_mem_sequencer;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 4;
  localparam int unsigned ACCW = 2 * DW + AW;

  typedef struct {
    int     addr;
    longint data;
    int     cyc;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [AW:0]     size_x_i;
  logic [AW:0]     size_h_i;
  logic [AW-1:0]   x_read_addr_o;
  logic [DW-1:0]   x_data_i;
  logic [AW-1:0]   h_read_addr_o;
  logic [DW-1:0]   h_data_i;
  logic            y_write_en_o;
  logic [AW:0]     y_write_addr_o;
  logic [ACCW-1:0] y_write_data_o;
  logic            busy_o;
  logic            done_o;

  logic [DW-1:0] x_mem [16];
  logic [DW-1:0] h_mem [16];

  wr_t exp_q[$];
  int  done_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  base = 0;
  int  busy_cnt = 0;
  int  busy_snap = 0;
  int  idle_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural X/H RAMs with one-cycle registered read.
  always @(posedge clk) begin
    x_data_i <= x_mem[x_read_addr_o];
    h_data_i <= h_mem[h_read_addr_o];
  end

  conv_mem_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ACC_WIDTH (ACCW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .size_x_i      (size_x_i),
    .size_h_i      (size_h_i),
    .x_read_addr_o (x_read_addr_o),
    .x_data_i      (x_data_i),
    .h_read_addr_o (h_read_addr_o),
    .h_data_i      (h_data_i),
    .y_write_en_o  (y_write_en_o),
    .y_write_addr_o(y_write_addr_o),
    .y_write_data_o(y_write_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic monitor_loop();
    wr_t e;
    int  d;
    forever begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (!busy_o && (|{x_read_addr_o, h_read_addr_o, y_write_en_o, done_o})) idle_bad++;
      if (!y_write_en_o && (|{y_write_addr_o, y_write_data_o})) idle_bad++;
      if (rst_n && y_write_en_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                   y_write_addr_o, y_write_data_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(y_write_addr_o), 64'(e.addr));
          check("wr_data", 64'(y_write_data_o), 64'(e.data));
          if (e.cyc >= 0) check("wr_cycle", 64'(cyc - base), 64'(e.cyc));
        end
      end
      if (rst_n && done_o) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done in cycle %0d, required none", cyc - base);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc - base), 64'(d));
        end
      end
    end
  endtask

  task automatic push_wr(input int addr, input longint data, input int c);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      x_mem[i] = '0;
      h_mem[i] = '0;
    end
  endtask

  task automatic load_t1();
    clear_mem();
    x_mem[0] = 8'd1;
    x_mem[1] = 8'd2;
    x_mem[2] = 8'd3;
    h_mem[0] = 8'd1;
    h_mem[1] = 8'd1;
  endtask

  task automatic push_t1();
    push_wr(0, 1, 4);
    push_wr(1, 3, 9);
    push_wr(2, 5, 14);
    push_wr(3, 3, 18);
    done_q.push_back(19);
  endtask

  // Start is sampled on the next rising edge; base makes that cycle's successor cycle 1.
  task automatic start_run(input int nx, input int nh, input bit hold);
    @(negedge clk);
    size_x_i = (AW + 1)'(nx);
    size_h_i = (AW + 1)'(nh);
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    base      = cyc - 1;
    busy_snap = busy_cnt;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_rel(input int c);
    for (int i = 0; i < 200 && (cyc - base) < c; i++) @(negedge clk);
  endtask

  task automatic finish_run(input string nm, input int budget, input int exp_busy);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done_o within %0d cycles, required done_o", nm, budget);
    end
    @(negedge clk);
    #1;
    check({nm, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_dones_left"}, 64'(done_q.size()), 64'd0);
    if (exp_busy >= 0) check({nm, "_busy_cycles"}, 64'(busy_cnt - busy_snap), 64'(exp_busy));
    check({nm, "_idle_outputs"}, 64'(idle_bad), 64'd0);
    check({nm, "_busy_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int l;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    size_x_i = '0;
    size_h_i = '0;
    clear_mem();
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_wen", 64'(y_write_en_o), 64'd0);
    check("rst_xaddr", 64'(x_read_addr_o), 64'd0);
    check("rst_ydata", 64'(y_write_data_o), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run with exact cycle positions.
    load_t1();
    push_t1();
    start_run(3, 2, 1'b0);
    finish_run("t1", 60, 19);

    // Full-length run of 0xFF: widest accumulation.
    for (int i = 0; i < 16; i++) begin
      x_mem[i] = 8'hFF;
      h_mem[i] = 8'hFF;
    end
    for (int n = 0; n < 31; n++) begin
      l = ((n < 15) ? n : 15) - ((n > 15) ? n - 15 : 0) + 1;
      push_wr(n, longint'(l) * 65025, -1);
    end
    done_q.push_back(350);
    start_run(16, 16, 1'b0);
    finish_run("t2", 500, 350);

    // Single x sample: every output has L=1.
    clear_mem();
    x_mem[0] = 8'd7;
    for (int i = 0; i < 4; i++) h_mem[i] = 8'(i + 1);
    for (int n = 0; n < 4; n++) push_wr(n, 7 * (n + 1), 4 + 4 * n);
    done_q.push_back(17);
    start_run(1, 4, 1'b0);
    finish_run("t3", 60, 17);

    // Zero size: no writes, done in cycle 2.
    done_q.push_back(2);
    start_run(0, 5, 1'b0);
    finish_run("t4", 20, 2);

    // Oversized Nx clamps to 16; x[i]=i, h={2}.
    clear_mem();
    for (int i = 0; i < 16; i++) x_mem[i] = 8'(i);
    h_mem[0] = 8'd2;
    for (int n = 0; n < 16; n++) push_wr(n, 2 * n, 4 + 4 * n);
    done_q.push_back(65);
    start_run(31, 1, 1'b0);
    finish_run("t7", 100, 65);

    // Reset in the first READ of n=2 aborts the run.
    load_t1();
    push_wr(0, 1, 4);
    push_wr(1, 3, 9);
    start_run(3, 2, 1'b0);
    wait_rel(11);
    check("t5_xaddr_read", 64'(x_read_addr_o), 64'd1);
    check("t5_haddr_read", 64'(h_read_addr_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy_o), 64'd0);
    check("t5_rst_xaddr", 64'(x_read_addr_o), 64'd0);
    check("t5_rst_haddr", 64'(h_read_addr_o), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t5_idle_after_rst", 64'(busy_o), 64'd0);
    check("t5_writes_left", 64'(exp_q.size()), 64'd0);
    push_t1();
    start_run(3, 2, 1'b0);
    finish_run("t5_restart", 60, 19);

    // Mid-run start pulse and size change are ignored.
    load_t1();
    push_t1();
    start_run(3, 2, 1'b0);
    @(negedge clk);
    start_i  = 1'b1;
    size_x_i = 5'd16;
    size_h_i = 5'd16;
    @(negedge clk);
    start_i = 1'b0;
    finish_run("t6", 60, 19);

    // start_i held high re-accepts on the IDLE cycle after DONE.
    clear_mem();
    x_mem[0] = 8'd7;
    h_mem[0] = 8'd3;
    push_wr(0, 21, 4);
    push_wr(0, 21, 10);
    done_q.push_back(5);
    done_q.push_back(11);
    start_run(1, 1, 1'b1);
    wait_rel(7);
    start_i = 1'b0;
    finish_run("t8", 30, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
